// File: rtl/uram_pipelined_memory.sv
// Simple dual-port core-local memory: configurable read latency, byte-masked writes,
// selectable read-during-write behaviour and a zero-fill sweep after reset.
module uram_pipelined_memory #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDRESS_WIDTH = 12,
    parameter int READ_LATENCY  = 2,
    parameter int BYPASS        = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ren,
    input  logic [ADDRESS_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    input  logic                      wen,
    input  logic [ADDRESS_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH/8-1:0]   wmask,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic                      init_done
);
    // state   | meaning
    // ST_INIT | zero-fill sweep in progress, user ports ignored
    // ST_RUN  | array usable (init_done follows one cycle later)
    localparam int DEPTH  = 1 << ADDRESS_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 8");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [ADDRESS_WIDTH:0]   sweep_cnt;
    logic [ADDRESS_WIDTH:0]   sweep_cnt_next;
    logic                     sweep_we;
    logic                     init_done_q;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     rd_accept;
    logic                     wr_accept;
    logic                     collide;
    logic [DATA_WIDTH-1:0]    rd_old;
    logic [DATA_WIDTH-1:0]    rd_merged;
    logic [DATA_WIDTH-1:0]    rd_word;

    logic [DATA_WIDTH-1:0]    pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0]  pipe_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            sweep_cnt   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_next;
            sweep_cnt   <= sweep_cnt_next;
            init_done_q <= (state == ST_RUN);
        end
    end

    // The counter carries into its top bit on the last sweep write and then stops.
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        sweep_we       = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_we       = 1'b1;
                sweep_cnt_next = sweep_cnt + 1'b1;
                if (&sweep_cnt[ADDRESS_WIDTH-1:0]) begin
                    state_next = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    assign init_done = init_done_q;
    assign rd_accept = ren && init_done_q;
    assign wr_accept = wen && init_done_q;

    // Sweep writes are held off while reset is asserted so the array is left untouched.
    always_ff @(posedge clock) begin
        if (sweep_we && !reset) begin
            mem[sweep_cnt[ADDRESS_WIDTH-1:0]] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    assign rd_old = mem[raddr];

    always_comb begin
        rd_merged = rd_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (wmask[i]) begin
                rd_merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    assign collide = (BYPASS != 0) && wr_accept && (raddr == waddr);
    assign rd_word = collide ? rd_merged : rd_old;

    // The last stage only loads on a valid so dout holds the previously delivered word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_accept;
            if (rd_accept || READ_LATENCY > 1) begin
                pipe_data[0] <= rd_word;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1] || k < READ_LATENCY - 1) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    assign dout       = pipe_data[READ_LATENCY-1];
    assign dout_valid = pipe_valid[READ_LATENCY-1];

endmodule

// File: tb/tb_uram_pipelined_memory.sv
// Three memory configurations share one stimulus stream; a per-instance reference
// model pushes expected reads into scoreboards that are popped when outputs emerge.
module tb_uram_pipelined_memory;
    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int ND    = 3;
    localparam int LAT [ND] = '{1, 2, 4};
    localparam int BYP [ND] = '{0, 1, 0};
    localparam int INI [ND] = '{1, 1, 0};

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            ren;
    logic [AW-1:0]   raddr;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [DW/8-1:0] wmask;
    logic [DW-1:0]   din;
    logic [DW-1:0]   dout [ND];
    logic            dout_valid [ND];
    logic            init_done [ND];

    exp_t            sbq [ND][$];
    logic [DW-1:0]   model [ND][DEPTH];
    logic [DW-1:0]   last [ND];
    int              since_rel;
    int              checks = 0;
    int              errors = 0;

    always #5 clock = ~clock;

    uram_pipelined_memory #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(1),
                            .BYPASS(0), .INIT_ON_RESET(1)) u_a (
        .clock(clock), .reset(reset), .ren(ren), .raddr(raddr), .dout(dout[0]),
        .dout_valid(dout_valid[0]), .wen(wen), .waddr(waddr), .wmask(wmask), .din(din),
        .init_done(init_done[0]));

    uram_pipelined_memory #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(2),
                            .BYPASS(1), .INIT_ON_RESET(1)) u_b (
        .clock(clock), .reset(reset), .ren(ren), .raddr(raddr), .dout(dout[1]),
        .dout_valid(dout_valid[1]), .wen(wen), .waddr(waddr), .wmask(wmask), .din(din),
        .init_done(init_done[1]));

    uram_pipelined_memory #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(4),
                            .BYPASS(0), .INIT_ON_RESET(0)) u_c (
        .clock(clock), .reset(reset), .ren(ren), .raddr(raddr), .dout(dout[2]),
        .dout_valid(dout_valid[2]), .wen(wen), .waddr(waddr), .wmask(wmask), .din(din),
        .init_done(init_done[2]));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                             input logic [DW/8-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW/8; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic check_outputs();
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("init_done[%0d]@%0d", k, since_rel), {63'd0, init_done[k]},
                {63'd0, since_rel >= ((INI[k] != 0) ? 17 : 1)});
            if (sbq[k].size() > 0 && sbq[k][0].due == since_rel) begin
                e = sbq[k].pop_front();
                chk($sformatf("valid[%0d]@%0d", k, since_rel), {63'd0, dout_valid[k]}, 64'd1);
                chk($sformatf("dout[%0d]@%0d", k, since_rel), dout[k], e.data);
                last[k] = e.data;
            end else begin
                chk($sformatf("novalid[%0d]@%0d", k, since_rel), {63'd0, dout_valid[k]}, 64'd0);
                chk($sformatf("hold[%0d]@%0d", k, since_rel), dout[k], last[k]);
            end
        end
    endtask

    // Called at a falling edge: drives one cycle of stimulus and checks the result.
    task automatic step(input bit r, input int ra, input bit w, input int wa,
                        input logic [DW/8-1:0] m, input logic [DW-1:0] wd);
        logic [DW-1:0] rd_exp;
        ren = r; raddr = ra[AW-1:0]; wen = w; waddr = wa[AW-1:0]; wmask = m; din = wd;
        for (int k = 0; k < ND; k++) begin
            if (since_rel >= ((INI[k] != 0) ? 17 : 1)) begin
                rd_exp = model[k][ra];
                if (w && wa == ra && BYP[k] != 0) rd_exp = merge(model[k][ra], wd, m);
                if (r) sbq[k].push_back('{due: since_rel + LAT[k], data: rd_exp});
                if (w) model[k][wa] = merge(model[k][wa], wd, m);
            end
        end
        @(posedge clock);
        since_rel++;
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1; ren = 1'b0; wen = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("rst_dout[%0d]", k), dout[k], '0);
            chk($sformatf("rst_valid[%0d]", k), {63'd0, dout_valid[k]}, 64'd0);
            chk($sformatf("rst_init_done[%0d]", k), {63'd0, init_done[k]}, 64'd0);
            sbq[k].delete();
            last[k] = '0;
            if (INI[k] != 0) for (int a = 0; a < DEPTH; a++) model[k][a] = '0;
        end
        repeat (hold) @(negedge clock);
        reset = 1'b0;
        since_rel = 0;
    endtask

    initial begin
        reset = 1'b1; ren = 1'b0; wen = 1'b0; raddr = '0; waddr = '0; wmask = '0; din = '0;
        since_rel = 0;
        for (int a = 0; a < DEPTH; a++) begin
            u_a.mem[a] = {$urandom, $urandom};
            u_b.mem[a] = {$urandom, $urandom};
            model[2][a] = {$urandom, $urandom} | 64'h1;
            u_c.mem[a] = model[2][a];
        end
        @(negedge clock);
        do_reset(3);

        // Reads during the sweep; reset lands when sweep address 9 is next.
        for (int i = 0; i < 9; i++) step(1, i, 0, 0, '0, '0);
        do_reset(2);

        for (int i = 0; i < 18; i++) step(i % 3 == 0, i % DEPTH, 0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, '0, '0);
        idle(5);

        step(0, 0, 1, 5, 8'hFF, 64'hDEADBEEF_01234567);
        step(1, 5, 0, 0, '0, '0);
        idle(5);

        for (int i = 0; i < 8; i++) step(0, 0, 1, i, 8'hFF, {32'hC0DE0000 + i, 32'h0F0F0000 ^ i});
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, '0, '0);
        idle(5);

        step(0, 0, 1, 3, 8'hFF, {8{8'h11}});
        step(0, 0, 1, 3, 8'h0F, {8{8'hFF}});
        step(1, 3, 0, 0, '0, '0);
        step(0, 0, 1, 3, 8'h00, 64'h0123_4567_89AB_CDEF);
        step(1, 3, 0, 0, '0, '0);
        idle(5);

        step(0, 0, 1, 7, 8'hFF, {8{8'hAA}});
        step(1, 7, 1, 7, 8'hF0, {8{8'h55}});
        step(1, 7, 0, 0, '0, '0);
        step(1, 6, 1, 2, 8'h3C, {8{8'h77}});
        idle(5);

        // Reset while reads are still in flight.
        step(1, 1, 0, 0, '0, '0);
        step(1, 2, 0, 0, '0, '0);
        step(1, 3, 0, 0, '0, '0);
        do_reset(2);
        step(0, 0, 0, 0, '0, '0);
        step(0, 0, 1, 10, 8'hFF, 64'hCAFE_F00D_1234_5678);
        step(1, 10, 0, 0, '0, '0);
        for (int i = 0; i < 16; i++) step(i % 4 == 0, 10, 0, 0, '0, '0);
        step(0, 0, 1, 9, 8'hFF, 64'h0BAD_BEEF_0000_0009);
        step(1, 9, 0, 0, '0, '0);
        step(1, 10, 0, 0, '0, '0);
        idle(6);

        for (int k = 0; k < ND; k++)
            chk($sformatf("drained[%0d]", k), 64'(sbq[k].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
